redundant_instr_vote_fork: RTL and testbench

// Joins instruction-fetch requests from NUM_IN lockstep cores (DMR/TMR) into one ICache request.
// Per-cycle vote on the (valid, addr) tuple; forwards the unanimous or majority request.

---
 rtl/redundant_instr_vote_fork.sv | 148 ++++++++++++++
 tb/tb_redundant_instr_vote_fork.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/redundant_instr_vote_fork.sv
// Votes lockstep core fetch requests into a single ICache request and fans the response back out.
// Holds an issued request stable until the ICache accepts it; tracks per-channel faults and error cycles.
module redundant_instr_vote_fork #(
  parameter type         addr_t    = logic [31:0],
  parameter type         data_t    = logic [31:0],
  parameter int unsigned NUM_IN    = 3,
  parameter bit          MAJORITY  = 1'b1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic [NUM_IN-1:0]     valid_i,
  output logic [NUM_IN-1:0]     ready_o,
  input  addr_t [NUM_IN-1:0]    addr_i,
  output data_t [NUM_IN-1:0]    data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output addr_t                 addr_o,
  input  data_t                 data_i,
  output logic                  error_o,
  output logic [NUM_IN-1:0]     fault_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned TUP_W = $bits(addr_t) + 1;
  localparam int unsigned CNT_W = $clog2(NUM_IN + 1);
  localparam int unsigned IDX_W = $clog2(NUM_IN);
  localparam int unsigned HALF  = NUM_IN / 2;
  localparam bit          MAJ_EN = MAJORITY && (NUM_IN >= 3);

  typedef enum logic {PASS, HOLD} state_e;

  state_e                        state_q, state_d;
  addr_t                         addr_q, addr_d;
  logic [NUM_IN-1:0]             fault_q, fault_d;
  logic [ERR_CNT_W-1:0]          err_cnt_q, err_cnt_d;

  logic [NUM_IN-1:0][TUP_W-1:0]  tup;
  logic [NUM_IN-1:0][CNT_W-1:0]  match_cnt;
  logic                          unanimous;
  logic                          maj_found;
  logic [IDX_W-1:0]              maj_idx;
  logic                          fwd_valid;
  addr_t                         fwd_addr;
  logic                          err;
  logic [NUM_IN-1:0]             fault_set;

  // Count, for each channel, how many channels carry an identical {valid, addr} tuple.
  always_comb begin
    tup       = '0;
    match_cnt = '0;
    maj_found = 1'b0;
    maj_idx   = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      tup[i] = {valid_i[i], addr_i[i]};
    end
    for (int i = 0; i < NUM_IN; i++) begin
      for (int j = 0; j < NUM_IN; j++) begin
        if (tup[i] == tup[j]) begin
          match_cnt[i] = match_cnt[i] + CNT_W'(1);
        end
      end
    end
    // Lowest-numbered majority holder wins; all holders carry the same tuple anyway.
    for (int i = int'(NUM_IN) - 1; i >= 0; i--) begin
      if (match_cnt[i] > CNT_W'(HALF)) begin
        maj_found = 1'b1;
        maj_idx   = IDX_W'(i);
      end
    end
    unanimous = (match_cnt[0] == CNT_W'(NUM_IN));
  end

  // Forwarding decision, hold handshake, fault and error-counter updates.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fault_d   = fault_q;
    err_cnt_d = err_cnt_q;
    fwd_valid = 1'b0;
    fwd_addr  = addr_q;
    err       = 1'b0;
    fault_set = '0;
    case (state_q)
      PASS: begin
        if (unanimous) begin
          fwd_valid = valid_i[0];
          fwd_addr  = addr_i[0];
        end else if (MAJ_EN && maj_found) begin
          fwd_valid = valid_i[maj_idx];
          fwd_addr  = addr_i[maj_idx];
          err       = 1'b1;
          for (int i = 0; i < NUM_IN; i++) begin
            fault_set[i] = (tup[i] != tup[maj_idx]);
          end
        end else begin
          err = 1'b1;
        end
        if (fwd_valid && !ready_i) begin
          state_d = HOLD;
          addr_d  = fwd_addr;
        end
      end
      HOLD: begin
        fwd_valid = 1'b1;
        fwd_addr  = addr_q;
        if (ready_i) begin
          state_d = PASS;
        end
      end
      default: state_d = PASS;
    endcase
    if (clear_i) begin
      fault_d   = '0;
      err_cnt_d = '0;
    end else begin
      fault_d = fault_q | fault_set;
      if (err && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= PASS;
      addr_q    <= '0;
      fault_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      fault_q   <= fault_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Request path is combinational; reset must kill it immediately, not at the next edge.
  assign valid_o   = fwd_valid & ~rst_i;
  assign error_o   = err & ~rst_i;
  assign addr_o    = fwd_addr;
  assign ready_o   = {NUM_IN{valid_o & ready_i}};
  assign data_o    = {NUM_IN{data_i}};
  assign fault_o   = fault_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_redundant_instr_vote_fork.sv
// Bench for redundant_instr_vote_fork: directed scenarios plus randomized traffic against a tuple-voting model.
module tb_redundant_instr_vote_fork;

  localparam int unsigned N  = 3;
  localparam int unsigned CW = 2;
  typedef logic [15:0] a_t;
  typedef logic [31:0] d_t;

  logic          clk = 1'b0;
  logic          rst, clear, ready_i, valid_o, error_o;
  logic [N-1:0]  valid_i, ready_o, fault_o;
  a_t [N-1:0]    addr_i;
  d_t [N-1:0]    data_o;
  a_t            addr_o;
  d_t            data_i;
  logic [CW-1:0] err_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model state
  bit            m_hold;
  a_t            m_addr;
  logic [N-1:0]  m_fault;
  int            m_cnt;
  logic          exp_valid, exp_err;
  a_t            exp_addr;
  logic [N-1:0]  exp_fset, exp_ready;

  always #5 clk = ~clk;

  redundant_instr_vote_fork #(
    .addr_t(a_t), .data_t(d_t), .NUM_IN(N), .MAJORITY(1'b1), .ERR_CNT_W(CW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clear),
    .valid_i(valid_i), .ready_o(ready_o), .addr_i(addr_i), .data_o(data_o),
    .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o), .data_i(data_i),
    .error_o(error_o), .fault_o(fault_o), .err_cnt_o(err_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cores(input a_t a0, input a_t a1, input a_t a2, input logic [N-1:0] v);
    addr_i[0] = a0;
    addr_i[1] = a1;
    addr_i[2] = a2;
    valid_i   = v;
  endtask

  // Expected request-side outputs derived from the voting rules on whole tuples.
  function automatic void model_comb();
    logic [16:0] t [N];
    int best;
    bit  all_eq;
    for (int i = 0; i < N; i++) t[i] = {valid_i[i], addr_i[i]};
    exp_fset = '0;
    if (m_hold) begin
      exp_valid = 1'b1; exp_addr = m_addr; exp_err = 1'b0;
    end else begin
      best = -1;
      all_eq = 1'b1;
      for (int i = 0; i < N; i++) begin
        int c = 0;
        for (int j = 0; j < N; j++) if (t[i] == t[j]) c++;
        if (2 * c > N && best < 0) best = i;
        if (t[i] != t[0]) all_eq = 1'b0;
      end
      if (all_eq) begin
        exp_valid = valid_i[0]; exp_addr = addr_i[0]; exp_err = 1'b0;
      end else if (best >= 0) begin
        exp_valid = valid_i[best]; exp_addr = addr_i[best]; exp_err = 1'b1;
        for (int i = 0; i < N; i++) exp_fset[i] = (t[i] != t[best]);
      end else begin
        exp_valid = 1'b0; exp_addr = m_addr; exp_err = 1'b1;
      end
    end
    if (rst) begin
      exp_valid = 1'b0; exp_err = 1'b0;
    end
    exp_ready = (exp_valid && ready_i) ? '1 : '0;
  endfunction

  function automatic void model_clk();
    if (!m_hold) begin
      if (exp_valid && !ready_i) begin
        m_hold = 1'b1; m_addr = exp_addr;
      end
    end else if (ready_i) begin
      m_hold = 1'b0;
    end
    if (clear) begin
      m_fault = '0; m_cnt = 0;
    end else begin
      m_fault = m_fault | exp_fset;
      if (exp_err && m_cnt < (1 << CW) - 1) m_cnt++;
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; ready_i = 1'b1; data_i = 32'hA5A5_0001;
    set_cores(16'h100, 16'h100, 16'h100, 3'b111);
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    checks++; if (ready_o !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b exp 000", ready_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL reset_error: got %b exp 0", error_o); end
    tick();
    checks++; if (fault_o !== 3'b000) begin errors++; $display("FAIL reset_fault: got %b exp 000", fault_o); end
    checks++; if (err_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_errcnt: got %0d exp 0", err_cnt_o); end
    rst = 1'b0;
  endtask

  task automatic test_unanimous();
    set_cores(16'h100, 16'h100, 16'h100, 3'b111);
    ready_i = 1'b1; data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL unan_valid: got %b exp 1", valid_o); end
    checks++; if (addr_o !== 16'h100) begin errors++; $display("FAIL unan_addr: got %h exp 0100", addr_o); end
    checks++; if (ready_o !== 3'b111) begin errors++; $display("FAIL unan_ready: got %b exp 111", ready_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL unan_error: got %b exp 0", error_o); end
    for (int i = 0; i < N; i++) begin
      checks++; if (data_o[i] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unan_data%0d: got %h exp deadbeef", i, data_o[i]); end
    end
    tick();
    checks++; if (err_cnt_o !== 2'd0) begin errors++; $display("FAIL unan_errcnt: got %0d exp 0", err_cnt_o); end
  endtask

  task automatic test_majority();
    set_cores(16'h100, 16'h100, 16'h104, 3'b111);
    ready_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL maj_valid: got %b exp 1", valid_o); end
    checks++; if (addr_o !== 16'h100) begin errors++; $display("FAIL maj_addr: got %h exp 0100", addr_o); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL maj_error: got %b exp 1", error_o); end
    tick();
    checks++; if (fault_o !== 3'b100) begin errors++; $display("FAIL maj_fault: got %b exp 100", fault_o); end
    checks++; if (err_cnt_o !== 2'd1) begin errors++; $display("FAIL maj_errcnt: got %0d exp 1", err_cnt_o); end
  endtask

  task automatic test_no_majority();
    set_cores(16'h100, 16'h104, 16'h108, 3'b111);
    ready_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL nomaj_valid: got %b exp 0", valid_o); end
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL nomaj_error: got %b exp 1", error_o); end
    checks++; if (ready_o !== 3'b000) begin errors++; $display("FAIL nomaj_ready: got %b exp 000", ready_o); end
    tick();
    checks++; if (fault_o !== 3'b100) begin errors++; $display("FAIL nomaj_fault: got %b exp 100", fault_o); end
    checks++; if (err_cnt_o !== 2'd2) begin errors++; $display("FAIL nomaj_errcnt: got %0d exp 2", err_cnt_o); end
  endtask

  task automatic test_hold();
    set_cores(16'h200, 16'h200, 16'h200, 3'b111);
    ready_i = 1'b0;
    #1;
    checks++; if (addr_o !== 16'h200 || valid_o !== 1'b1) begin errors++; $display("FAIL hold_issue: got v=%b a=%h exp v=1 a=0200", valid_o, addr_o); end
    tick();
    set_cores(16'h300, 16'h300, 16'h300, 3'b111);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (addr_o !== 16'h200 || valid_o !== 1'b1 || error_o !== 1'b0) begin
        errors++; $display("FAIL hold_stable%0d: got v=%b a=%h e=%b exp v=1 a=0200 e=0", k, valid_o, addr_o, error_o);
      end
      tick();
    end
    ready_i = 1'b1;
    #1;
    checks++; if (addr_o !== 16'h200 || ready_o !== 3'b111) begin errors++; $display("FAIL hold_accept: got a=%h r=%b exp a=0200 r=111", addr_o, ready_o); end
    tick();
    checks++; if (addr_o !== 16'h300 || valid_o !== 1'b1) begin errors++; $display("FAIL hold_release: got v=%b a=%h exp v=1 a=0300", valid_o, addr_o); end
    checks++; if (err_cnt_o !== 2'd2) begin errors++; $display("FAIL hold_errcnt: got %0d exp 2", err_cnt_o); end
    tick();
  endtask

  task automatic test_saturate_clear();
    set_cores(16'h0, 16'h0, 16'h0, 3'b000);
    clear = 1'b1; ready_i = 1'b1;
    tick();
    clear = 1'b0;
    checks++; if (err_cnt_o !== 2'd0 || fault_o !== 3'b000) begin errors++; $display("FAIL clr_idle: got c=%0d f=%b exp c=0 f=000", err_cnt_o, fault_o); end
    set_cores(16'h100, 16'h104, 16'h108, 3'b111);
    for (int k = 0; k < 5; k++) tick();
    checks++; if (err_cnt_o !== 2'd3) begin errors++; $display("FAIL sat_errcnt: got %0d exp 3", err_cnt_o); end
    set_cores(16'h100, 16'h104, 16'h100, 3'b111);
    clear = 1'b1;
    #1;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL clr_error: got %b exp 1", error_o); end
    tick();
    clear = 1'b0;
    checks++; if (err_cnt_o !== 2'd0 || fault_o !== 3'b000) begin errors++; $display("FAIL clr_prio: got c=%0d f=%b exp c=0 f=000", err_cnt_o, fault_o); end
  endtask

  task automatic test_reset_in_hold();
    set_cores(16'h200, 16'h200, 16'h200, 3'b111);
    ready_i = 1'b0;
    tick();
    set_cores(16'h100, 16'h108, 16'h104, 3'b111);
    tick();
    ready_i = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b1 || addr_o !== 16'h200) begin errors++; $display("FAIL rsthold_pre: got v=%b a=%h exp v=1 a=0200", valid_o, addr_o); end
    #1 rst = 1'b1;
    #1;
    checks++; if (valid_o !== 1'b0 || ready_o !== 3'b000) begin errors++; $display("FAIL rsthold_drop: got v=%b r=%b exp v=0 r=000", valid_o, ready_o); end
    tick();
    rst = 1'b0;
    set_cores(16'h500, 16'h500, 16'h500, 3'b111);
    ready_i = 1'b0;
    #1;
    checks++; if (valid_o !== 1'b1 || addr_o !== 16'h500) begin errors++; $display("FAIL rsthold_pass: got v=%b a=%h exp v=1 a=0500", valid_o, addr_o); end
    checks++; if (err_cnt_o !== 2'd0) begin errors++; $display("FAIL rsthold_errcnt: got %0d exp 0", err_cnt_o); end
    ready_i = 1'b1;
    tick();
  endtask

  task automatic test_random();
    rst = 1'b1; clear = 1'b0; ready_i = 1'b0;
    tick();
    rst = 1'b0;
    m_hold = 1'b0; m_addr = '0; m_fault = '0; m_cnt = 0;
    for (int n = 0; n < 400; n++) begin
      a_t   base = a_t'(16'h100 + 4 * $urandom_range(0, 3));
      logic vb   = ($urandom_range(0, 4) != 0);
      int   di   = $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) begin
        addr_i[i]  = ($urandom_range(0, 3) == 0) ? a_t'(16'h100 + 4 * $urandom_range(0, 3)) : base;
        valid_i[i] = ($urandom_range(0, 7) == 0) ? ~vb : vb;
      end
      ready_i = ($urandom_range(0, 2) != 0);
      clear   = ($urandom_range(0, 15) == 0);
      data_i  = $urandom;
      #1;
      model_comb();
      checks++; if (valid_o !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, valid_o, exp_valid); end
      checks++; if (addr_o !== exp_addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h exp %h", n, addr_o, exp_addr); end
      checks++; if (error_o !== exp_err) begin errors++; $display("FAIL rnd_error[%0d]: got %b exp %b", n, error_o, exp_err); end
      checks++; if (ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d]: got %b exp %b", n, ready_o, exp_ready); end
      checks++; if (data_o[di] !== data_i) begin errors++; $display("FAIL rnd_data[%0d]: got %h exp %h", n, data_o[di], data_i); end
      @(posedge clk);
      model_clk();
      #1;
      checks++; if (fault_o !== m_fault) begin errors++; $display("FAIL rnd_fault[%0d]: got %b exp %b", n, fault_o, m_fault); end
      checks++; if (int'(err_cnt_o) != m_cnt) begin errors++; $display("FAIL rnd_errcnt[%0d]: got %0d exp %0d", n, err_cnt_o, m_cnt); end
    end
    clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_unanimous();
    test_majority();
    test_no_majority();
    test_hold();
    test_saturate_clear();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
